// File: rtl/dual_issue_scoreboard.sv
// dual_issue_scoreboard: in-order even/odd pair issue stage with a 128-entry result-latency scoreboard.
// Unissued slots drive NOP/LNOP so the register file always sees a legal read.
module dual_issue_scoreboard #(
    parameter int          LAT_W    = 3,
    parameter logic [0:31] NOP_EVEN = 32'h40200000,
    parameter logic [0:31] NOP_ODD  = 32'h00200000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pair_valid_in,
    output logic             pair_ready_out,
    input  logic [0:31]      inst_even_in,
    input  logic [0:31]      inst_odd_in,
    input  logic             even_valid_in,
    input  logic             odd_valid_in,
    input  logic [0:2]       even_uses_in,
    input  logic [0:2]       odd_uses_in,
    input  logic             even_write_in,
    input  logic             odd_write_in,
    input  logic [0:6]       even_rt_in,
    input  logic [0:6]       odd_rt_in,
    input  logic [LAT_W-1:0] even_lat_in,
    input  logic [LAT_W-1:0] odd_lat_in,
    input  logic             flush_in,
    output logic [0:31]      instruction_even,
    output logic [0:31]      instruction_odd,
    output logic             issue_even_out,
    output logic             issue_odd_out,
    output logic [0:6]       even_rt_out,
    output logic [0:6]       odd_rt_out,
    output logic             even_write_out,
    output logic             odd_write_out
);
    logic             ev_q, od_q, ev_d, od_d;
    logic [0:31]      ie_q, io_q;
    logic [0:2]       ue_q, uo_q;
    logic             we_q, wo_q;
    logic [0:6]       rte_q, rto_q;
    logic [LAT_W-1:0] le_q, lo_q, lat_e, lat_o;
    logic [LAT_W-1:0] cnt_q [128];
    logic [LAT_W-1:0] cnt_d [128];
    logic [0:6]       ra_e, rb_e, rc_e, ra_o, rb_o, rc_o;
    logic             busy_e, busy_o, waw_e, waw_o, intra, iss_e, iss_o, capture;

    assign ra_e = ie_q[18:24];
    assign rb_e = ie_q[11:17];
    assign rc_e = ie_q[25:31];
    assign ra_o = io_q[18:24];
    assign rb_o = io_q[11:17];
    assign rc_o = io_q[25:31];
    assign lat_e = (le_q == '0) ? LAT_W'(1) : le_q;
    assign lat_o = (lo_q == '0) ? LAT_W'(1) : lo_q;

    // A count of 1 means the result forwards next edge, so only >1 stalls a reader.
    assign busy_e = (ue_q[0] && cnt_q[ra_e] > LAT_W'(1)) || (ue_q[1] && cnt_q[rb_e] > LAT_W'(1))
                 || (ue_q[2] && cnt_q[rc_e] > LAT_W'(1));
    assign busy_o = (uo_q[0] && cnt_q[ra_o] > LAT_W'(1)) || (uo_q[1] && cnt_q[rb_o] > LAT_W'(1))
                 || (uo_q[2] && cnt_q[rc_o] > LAT_W'(1));
    assign waw_e = we_q && cnt_q[rte_q] > lat_e;
    assign waw_o = wo_q && cnt_q[rto_q] > lat_o;

    assign iss_e = ev_q && !busy_e && !waw_e && !flush_in;
    assign intra = iss_e && we_q && ((uo_q[0] && ra_o == rte_q) || (uo_q[1] && rb_o == rte_q)
                 || (uo_q[2] && rc_o == rte_q) || rto_q == rte_q);
    assign iss_o = od_q && (iss_e || !ev_q) && !busy_o && !waw_o && !intra && !flush_in;

    assign pair_ready_out = flush_in || ((!ev_q || iss_e) && (!od_q || iss_o));
    assign capture = pair_valid_in && pair_ready_out && !flush_in;
    assign ev_d = flush_in ? 1'b0 : capture ? even_valid_in : ev_q && !iss_e;
    assign od_d = flush_in ? 1'b0 : capture ? odd_valid_in : od_q && !iss_o;

    always_comb begin
        for (int r = 0; r < 128; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : cnt_q[r];
            if (iss_e && we_q && rte_q == 7'(r)) cnt_d[r] = lat_e;
            if (iss_o && wo_q && rto_q == 7'(r)) cnt_d[r] = lat_o;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 128; r++) cnt_q[r] <= '0;
            ev_q <= 1'b0;
            od_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ev_q <= ev_d;
            od_q <= od_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ie_q  <= '0;
            io_q  <= '0;
            ue_q  <= '0;
            uo_q  <= '0;
            we_q  <= 1'b0;
            wo_q  <= 1'b0;
            rte_q <= '0;
            rto_q <= '0;
            le_q  <= '0;
            lo_q  <= '0;
        end else if (capture) begin
            ie_q  <= inst_even_in;
            io_q  <= inst_odd_in;
            ue_q  <= even_uses_in;
            uo_q  <= odd_uses_in;
            we_q  <= even_write_in;
            wo_q  <= odd_write_in;
            rte_q <= even_rt_in;
            rto_q <= odd_rt_in;
            le_q  <= even_lat_in;
            lo_q  <= odd_lat_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instruction_even <= NOP_EVEN;
            instruction_odd  <= NOP_ODD;
            issue_even_out   <= 1'b0;
            issue_odd_out    <= 1'b0;
            even_rt_out      <= '0;
            odd_rt_out       <= '0;
            even_write_out   <= 1'b0;
            odd_write_out    <= 1'b0;
        end else begin
            instruction_even <= iss_e ? ie_q : NOP_EVEN;
            instruction_odd  <= iss_o ? io_q : NOP_ODD;
            issue_even_out   <= iss_e;
            issue_odd_out    <= iss_o;
            even_rt_out      <= iss_e ? rte_q : '0;
            odd_rt_out       <= iss_o ? rto_q : '0;
            even_write_out   <= iss_e && we_q;
            odd_write_out    <= iss_o && wo_q;
        end
    end
endmodule
